// File: rtl/pipe_rca.sv
// Pipelined ripple-carry add/subtract: one WIDTH/STAGES-bit chunk per stage, carry registered between stages.
// Latency STAGES cycles, one op per cycle; a stalled output (out_valid && !out_ready) freezes the whole pipe.
module pipe_rca #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C = (STAGES > 0) ? WIDTH / STAGES : 1;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipe_rca: WIDTH must be a non-zero multiple of STAGES");
  end

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO  = s * C;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]  a_i;
    logic [REM-1:0]  b_i;
    logic            c_i;
    logic            v_i;
    logic [LO+C-1:0] s_n;
    logic [C:0]      add;
    logic            v_q, v_d;
    logic            c_q, c_d;
    logic [LO+C-1:0] s_q, s_d;

    assign add = {1'b0, a_i[C-1:0]} + {1'b0, b_i[C-1:0]} + {{C{1'b0}}, c_i};

    if (s == 0) begin : g_src
      assign a_i = op1;
      assign b_i = sub ? ~op2 : op2;
      assign c_i = sub | cin;
      assign v_i = in_valid;
      assign s_n = add[C-1:0];
    end else begin : g_src
      // Operand chunks arrive via the previous stage's skew registers.
      assign a_i = g_stg[s-1].g_skew.a_q;
      assign b_i = g_stg[s-1].g_skew.b_q;
      assign c_i = g_stg[s-1].c_q;
      assign v_i = g_stg[s-1].v_q;
      assign s_n = {add[C-1:0], g_stg[s-1].s_q};
    end

    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (adv) begin
        v_d = v_i;
        c_d = add[C];
        s_d = s_n;
      end
      if (flush) begin
        v_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (s < STAGES - 1) begin : g_skew
      logic [REM-C-1:0] a_q, a_d;
      logic [REM-C-1:0] b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv) begin
          a_d = a_i[REM-1:C];
          b_d = b_i[REM-1:C];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_last
      logic ovf_q, ovf_d;

      // Carry into the MSB recovered from the MSB sum bit, then compared with carry out.
      always_comb begin
        ovf_d = ovf_q;
        if (adv) begin
          ovf_d = (a_i[C-1] ^ b_i[C-1] ^ add[C-1]) ^ add[C];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipe_rca.sv
// Directed bench for pipe_rca with a result scoreboard fed at input acceptance.
module tb_pipe_rca;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, cin, sub;
  logic         out_valid, out_ready, cout, ovf;
  logic [W-1:0] op1, op2, sum;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  res_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipe_rca #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    res_t         r;
    logic [W:0]   full;
    logic [W-1:0] be;
    be   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (s ? 1'b1 : c)};
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.o  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  // One clock cycle: sample mid-cycle, score output handshake, record accepted input.
  task automatic tick();
    res_t e;
    #4;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_sum",  64'(sum),  64'(e.s));
        chk("sb_cout", 64'(cout), 64'(e.c));
        chk("sb_ovf",  64'(ovf),  64'(e.o));
      end
    end
    if (rst || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(op1, op2, cin, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
    op1 = a; op2 = b; cin = c; sub = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 50) begin
      tick();
      k++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    int           idx;
    logic [W-1:0] sa [8];
    logic [W-1:0] sb [8];
    logic         sc [8];
    logic         ss [8];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op1 = '0; op2 = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_cout",      64'(cout),      64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // Full carry ripple to the top with latency measurement.
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_valid(n);
    chk("latency_first", 64'(n), 64'd3);
    chk("first_sum",  64'(sum),  64'h0);
    chk("first_cout", 64'(cout), 64'd1);
    chk("first_ovf",  64'(ovf),  64'd0);
    tick();

    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    drain();

    // Back-to-back random stream with a three-cycle output stall.
    for (int i = 0; i < 8; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
      sc[i] = 1'($urandom); ss[i] = 1'($urandom);
    end
    idx = 0;
    for (int cyc = 0; cyc < 60 && (idx < 8 || exp_q.size() > 0); cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        op1 = sa[idx]; op2 = sb[idx]; cin = sc[idx]; sub = ss[idx];
      end
      #1;
      if (!out_ready) begin
        chk("stall_in_ready",  64'(in_ready),  64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        if (exp_q.size() > 0) begin
          chk("stall_sum",  64'(sum),  64'(exp_q[0].s));
          chk("stall_cout", 64'(cout), 64'(exp_q[0].c));
          chk("stall_ovf",  64'(ovf),  64'(exp_q[0].o));
        end
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", 64'(idx), 64'd8);
    chk("stream_drained",  64'(exp_q.size()), 64'd0);

    // Flush with two ops in flight plus one presented in the flush cycle.
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    send(32'h3333_3333, 32'h0000_0001, 1'b0, 1'b1);
    flush = 1'b1;
    op1 = 32'h0000_0009; op2 = 32'h0000_0001; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_out", 64'(out_valid), 64'd0);
      tick();
    end

    // Reset while a result is held at the stalled output.
    out_ready = 1'b0;
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_valid(n);
    chk("pre_rst_sum", 64'(sum), 64'h7FFF_FFFF);
    rst = 1'b1;
    op1 = 32'h0000_0004; op2 = 32'h0000_0004; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum",       64'(sum),       64'd0);
    chk("midrst_cout",      64'(cout),      64'd0);
    chk("midrst_ovf",       64'(ovf),       64'd0);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    send(32'h0000_00FF, 32'h0000_0F01, 1'b0, 1'b0);
    wait_valid(n);
    chk("latency_after_rst", 64'(n), 64'd3);
    chk("after_rst_sum", 64'(sum), 64'h0000_1000);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_rca.md
Name: pipe_rca

Overview:
- Parametrised, pipelined successor to the single-cycle ripple-carry adder used inside the multiplier datapath.
- Splits a WIDTH-bit add/subtract into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages.
- Supports carry-in, subtract mode, signed-overflow flag and valid/ready flow control with backpressure.
- Serves the multiplier's final carry-propagate add and any multi-cycle EX arithmetic.

Parameters:
- WIDTH, 32, operand/result width in bits (matches DATA_BUS_WIDTH).
- STAGES, 4, number of pipeline stages, which is also the latency; WIDTH % STAGES must be 0, STAGES >= 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous clear of all in-flight operations.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  the pipe can accept an operation this cycle.
- op1  input  WIDTH  first operand.
- op2  input  WIDTH  second operand.
- cin  input  1  carry-in; used only in add mode.
- sub  input  1  0 selects op1+op2+cin; 1 selects op1-op2.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out; in subtract mode, 1 means no borrow (op1 >= op2 unsigned).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Chunk width C = WIDTH/STAGES. Stage s (0..STAGES-1) adds bits [s*C +: C] of op1 and the effective op2, with carry-in taken from stage s-1's carry register.
- Stage 0 carry-in is cin in add mode and 1 in subtract mode.
- Effective op2 is op2 in add mode and ~op2 in subtract mode; cin is ignored when sub=1.
- Upper operand chunks travel through skew registers until they reach their stage. Completed lower sum chunks travel forward through deskew registers, so the whole result leaves aligned.
- Each stage holds a valid bit.
- Advance enable is adv = !out_valid || out_ready; in_ready = adv, combinational.
- When adv=1, every stage shifts forward one position.
  - Stage 0 loads if in_valid && in_ready; otherwise it loads a bubble (valid=0).
- When adv=0, the whole pipe holds. Outputs must stay bit-stable while out_valid=1 && out_ready=0.
- Latency: an operation accepted at edge k appears with out_valid=1 after edge k+STAGES-1. With no stall, one result per cycle.
- cout is the carry out of the top chunk.
- ovf = (carry into bit WIDTH-1) XOR cout, computed in the last stage.
- STAGES=1 degenerates to a single registered full-width adder with latency 1.
- rst=1 or flush=1: all valid bits go to 0 at the edge, and out_valid=0 on the next cycle.
  - sum, cout, ovf reset to 0 on rst; flush clears only the valid bits.
  - rst has priority over flush.
  - An operation presented in the same cycle as rst or flush is dropped.
- Simultaneous accept at the input and drain at the output is always allowed; there is no bubble penalty.
- Ordering is strictly FIFO; no operation is lost or duplicated under any out_ready pattern.
- Out-of-range parameters (WIDTH % STAGES != 0): elaboration-time error.

Test Plan:
- Defaults, add, 0xFFFFFFFF + 0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- Add 0x7FFFFFFF + 0x00000001 -> 0x80000000, cout=0, ovf=1.
- Add 0x00FFFFFF + 0x00000000 with cin=1 -> 0x01000000, checking carry ripple across three chunk boundaries.
- Sub 5-7 -> 0xFFFFFFFE, cout=0, ovf=0. Sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, cout=1, ovf=1.
- Stream 8 back-to-back random ops with out_ready=0 for cycles 5..7 -> in_ready=0 while stalled, held outputs stable, all 8 results in order, matching a reference model.
- Assert flush at cycle 2 with 2 ops in flight -> no out_valid from them. Repeat with rst mid-stream -> out_valid=0, sum=0, cout=0, ovf=0; a new op after release completes normally with latency 4.
